// File: rtl/r_norm_engine_if.sv
// r_norm_engine_if: control, R-memory read port and result bus of the norm engine
//   master: start, row_count, threshold, memory_output -> engine
//   slave : input_read_address, busy, done, result, converged, overflow -> controller/memory
interface r_norm_engine_if #(
   parameter int element_width = 32,
   parameter int no_of_units   = 8,
   parameter int address_width = 20,
   parameter int acc_width     = 64
);
   logic                                   start;
   logic        [address_width-1:0]        row_count;
   logic signed [acc_width-1:0]            threshold;
   logic        [no_of_units*element_width-1:0] memory_output;
   logic        [address_width-1:0]        input_read_address;
   logic                                   busy;
   logic                                   done;
   logic signed [acc_width-1:0]            result;
   logic                                   converged;
   logic                                   overflow;
   modport master (
      output start, row_count, threshold, memory_output,
      input  input_read_address, busy, done, result, converged, overflow
   );
   modport slave (
      input  start, row_count, threshold, memory_output,
      output input_read_address, busy, done, result, converged, overflow
   );
endinterface

// File: rtl/r_norm_engine.sv
// r_norm_engine: squared Euclidean norm r.r of the R memory with saturation and convergence flag
//   clk, reset : clock, asynchronous active-high reset
//   bus (slave): start/row_count/threshold in, memory_output row data in,
//                input_read_address out, busy/done/result/converged/overflow out
module r_norm_engine #(
   parameter int element_width = 32,
   parameter int no_of_units   = 8,
   parameter int address_width = 20,
   parameter int frac_bits     = 16,
   parameter int acc_width     = 64
) (
   input logic            clk,
   input logic            reset,
   r_norm_engine_if.slave bus
);
   localparam int sw = acc_width + 3;
   localparam logic signed [acc_width-1:0] amax = {1'b0, {(acc_width-1){1'b1}}};
   localparam logic signed [acc_width-1:0] amin = {1'b1, {(acc_width-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
   state_t                         state_q, state_d;
   logic [address_width-1:0]       addr_q, addr_d, rows_q;
   logic signed [acc_width-1:0]    thr_q, acc_q, acc_nx, acc_fin;
   logic [no_of_units*element_width-1:0] s1_q;
   logic signed [sw-1:0]           s2_d [no_of_units];
   logic signed [sw-1:0]           s2_q [no_of_units];
   logic signed [sw-1:0]           s3_q, tree;
   logic signed [sw:0]             sum;
   logic s1_v_q, s1_l_q, s2_v_q, s2_l_q, s3_v_q, s3_l_q;
   logic done_q, conv_q, ovf_q, accept, last_row, finish, hi, lo;
   for (genvar i = 0; i < no_of_units; i++) begin : g_lane
      logic signed [element_width-1:0]   lane;
      logic signed [2*element_width-1:0] prod;
      assign lane    = s1_q[i*element_width +: element_width];
      assign prod    = (2*element_width)'(lane) * (2*element_width)'(lane);
      assign s2_d[i] = sw'(prod >>> frac_bits);
   end
   always_comb begin
      tree = '0;
      for (int j = 0; j < no_of_units; j++) tree = tree + s2_q[j];
   end
   // sum is one bit wider than either operand so the range test cannot itself wrap
   assign sum      = (sw+1)'(acc_q) + (sw+1)'(s3_q);
   assign hi       = sum > (sw+1)'(amax);
   assign lo       = sum < (sw+1)'(amin);
   assign acc_nx   = hi ? amax : lo ? amin : acc_width'(sum);
   assign acc_fin  = s3_v_q ? acc_nx : acc_q;
   assign accept   = state_q == IDLE && bus.start;
   assign last_row = addr_q == rows_q - 1'b1;
   // an empty sweep never produces a tagged row, so it finishes on its first DRAIN cycle
   assign finish   = state_q == DRAIN && (s3_v_q && s3_l_q || rows_q == '0);
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (accept) begin
         state_d = bus.row_count == '0 ? DRAIN : SWEEP;
         addr_d  = '0;
      end else if (state_q == SWEEP) begin
         state_d = last_row ? DRAIN : SWEEP;
         addr_d  = last_row ? addr_q : addr_q + 1'b1;
      end else if (finish) state_d = IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rows_q  <= '0;
         thr_q   <= '0;
         acc_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '{default: '0};
         s3_q    <= '0;
         s1_v_q  <= 1'b0;
         s1_l_q  <= 1'b0;
         s2_v_q  <= 1'b0;
         s2_l_q  <= 1'b0;
         s3_v_q  <= 1'b0;
         s3_l_q  <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         s1_q    <= bus.memory_output;
         s1_v_q  <= state_q == SWEEP;
         s1_l_q  <= last_row;
         s2_q    <= s2_d;
         s2_v_q  <= s1_v_q;
         s2_l_q  <= s1_l_q;
         s3_q    <= tree;
         s3_v_q  <= s2_v_q;
         s3_l_q  <= s2_l_q;
         done_q  <= finish;
         if (accept) begin
            rows_q <= bus.row_count;
            thr_q  <= bus.threshold;
            acc_q  <= '0;
            conv_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else begin
            if (s3_v_q) begin
               acc_q <= acc_nx;
               ovf_q <= ovf_q | hi | lo;
            end
            if (finish) conv_q <= acc_fin < thr_q;
         end
      end
   assign bus.input_read_address = addr_q;
   assign bus.busy               = state_q != IDLE;
   assign bus.done               = done_q;
   assign bus.result             = acc_q;
   assign bus.converged          = conv_q;
   assign bus.overflow           = ovf_q;
endmodule

// File: tb/tb_r_norm_engine.sv
// tb_r_norm_engine: randomized and directed checks of r_norm_engine against an arithmetic model
module tb_r_norm_engine;
   localparam logic signed [63:0]  AMAX   = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] MAX128 = {64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
   localparam logic signed [127:0] MIN128 = {{64{1'b1}}, 64'h8000_0000_0000_0000};
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0;
   int total = 0;
   logic [255:0] mem [64];
   r_norm_engine_if #(.element_width(32), .no_of_units(8), .address_width(20), .acc_width(64)) b ();
   r_norm_engine_if #(.element_width(32), .no_of_units(8), .address_width(20), .acc_width(64)) b0 ();
   r_norm_engine #(.element_width(32), .no_of_units(8), .address_width(20), .frac_bits(16), .acc_width(64))
      dut (.clk(clk), .reset(reset), .bus(b));
   r_norm_engine #(.element_width(32), .no_of_units(8), .address_width(20), .frac_bits(0), .acc_width(64))
      dut0 (.clk(clk), .reset(reset), .bus(b0));
   assign b.memory_output  = mem[b.input_read_address[5:0]];
   assign b0.memory_output = mem[b0.input_read_address[5:0]];
   always #5 clk = ~clk;
   // sum over rows and lanes of floor(lane^2 / 2^frac), clamped to the signed 64-bit range after each row
   function automatic void model(input int n, input int frac, output logic signed [63:0] res, output logic ovf);
      logic signed [127:0] acc, p;
      logic signed [31:0]  lane;
      acc = '0;
      ovf = 1'b0;
      for (int r = 0; r < n; r++) begin
         p = '0;
         for (int l = 0; l < 8; l++) begin
            lane = mem[r][l*32 +: 32];
            p = p + ((128'(lane) * 128'(lane)) >>> frac);
         end
         acc = acc + p;
         if (acc > MAX128) begin acc = MAX128; ovf = 1'b1; end
         if (acc < MIN128) begin acc = MIN128; ovf = 1'b1; end
      end
      res = acc[63:0];
   endfunction
   task automatic run_sweep(input int n, input logic signed [63:0] thr, input int pulse_at,
                            output int lat, output int bad_addr, output int bad_busy);
      @(negedge clk);
      b.row_count = 20'(n);
      b.threshold = thr;
      b.start = 1'b1;
      @(posedge clk); #1;
      b.start = 1'b0;
      lat = -1;
      bad_addr = 0;
      bad_busy = 0;
      if (n > 0 && b.input_read_address !== 20'd0) bad_addr++;
      if (b.busy !== 1'b1) bad_busy++;
      for (int c = 1; c <= n + 20; c++) begin
         @(posedge clk); #1;
         b.start = (c == pulse_at);
         if (c < n && b.input_read_address !== 20'(c)) bad_addr++;
         if (b.busy !== !b.done) bad_busy++;
         if (b.done === 1'b1) begin
            lat = c;
            break;
         end
      end
      b.start = 1'b0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      b.start = 1'b0; b.row_count = '0; b.threshold = '0;
      b0.start = 1'b0; b0.row_count = '0; b0.threshold = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (b.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", b.busy); else passed++;
      total++; if (b.done !== 1'b0) $display("FAIL reset_done got %0b want 0", b.done); else passed++;
      total++; if (b.result !== 64'd0) $display("FAIL reset_result got %h want 0", b.result); else passed++;
      total++; if (b.converged !== 1'b0) $display("FAIL reset_conv got %0b want 0", b.converged); else passed++;
      total++; if (b.overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", b.overflow); else passed++;
      total++; if (b.input_read_address !== 20'd0) $display("FAIL reset_addr got %0d want 0", b.input_read_address); else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic test_empty;
      int lat, ba, bb;
      logic signed [63:0] thr;
      thr = 64'($urandom_range(1, 1000));
      run_sweep(0, thr, 0, lat, ba, bb);
      total++; if (lat !== 1) $display("FAIL empty_latency got %0d want 1", lat); else passed++;
      total++; if (b.result !== 64'd0) $display("FAIL empty_result got %h want 0", b.result); else passed++;
      total++; if (b.converged !== 1'b1) $display("FAIL empty_conv got %0b want 1", b.converged); else passed++;
      total++; if (bb !== 0) $display("FAIL empty_busy got %0d bad cycles want 0", bb); else passed++;
      total++; if (b.input_read_address !== 20'd0) $display("FAIL empty_addr got %0d want 0", b.input_read_address); else passed++;
      @(posedge clk); #1;
      total++; if (b.done !== 1'b0) $display("FAIL empty_done_width got %0b want 0", b.done); else passed++;
   endtask
   task automatic test_all_ones;
      int lat, ba, bb;
      for (int r = 0; r < 4; r++) mem[r] = {8{32'h0001_0000}};
      run_sweep(4, 64'h21_0000, 0, lat, ba, bb);
      total++; if (lat !== 7) $display("FAIL ones_latency got %0d want 7", lat); else passed++;
      total++; if (b.result !== 64'h20_0000) $display("FAIL ones_result got %h want 200000", b.result); else passed++;
      total++; if (b.converged !== 1'b1) $display("FAIL ones_conv got %0b want 1", b.converged); else passed++;
      total++; if (b.overflow !== 1'b0) $display("FAIL ones_ovf got %0b want 0", b.overflow); else passed++;
      total++; if (ba !== 0) $display("FAIL ones_addr got %0d bad addresses want 0", ba); else passed++;
      total++; if (bb !== 0) $display("FAIL ones_busy got %0d bad cycles want 0", bb); else passed++;
      @(posedge clk); #1;
      total++; if (b.done !== 1'b0) $display("FAIL ones_done_width got %0b want 0", b.done); else passed++;
      total++; if (b.result !== 64'h20_0000) $display("FAIL ones_hold got %h want 200000", b.result); else passed++;
   endtask
   task automatic test_negative;
      int lat, ba, bb;
      mem[0] = {8{32'hFFFE_0000}};
      run_sweep(1, 64'h20_0000, 0, lat, ba, bb);
      total++; if (lat !== 4) $display("FAIL neg_latency got %0d want 4", lat); else passed++;
      total++; if (b.result !== 64'h20_0000) $display("FAIL neg_result got %h want 200000", b.result); else passed++;
      total++; if (b.converged !== 1'b0) $display("FAIL neg_conv got %0b want 0", b.converged); else passed++;
   endtask
   task automatic test_random;
      int lat, ba, bb, n, k;
      logic signed [63:0] res, thr;
      logic ovf;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 24);
         for (int r = 0; r < n; r++)
            for (int l = 0; l < 8; l++) mem[r][l*32 +: 32] = $urandom;
         model(n, 16, res, ovf);
         k = $urandom_range(0, 2);
         thr = k == 0 ? res - 64'sd1 : k == 1 ? res : res + 64'sd1;
         run_sweep(n, thr, 0, lat, ba, bb);
         total++; if (lat !== n + 3) $display("FAIL rand_latency n=%0d got %0d want %0d", n, lat, n + 3); else passed++;
         total++; if (b.result !== res) $display("FAIL rand_result n=%0d got %h want %h", n, b.result, res); else passed++;
         total++; if (b.converged !== (res < thr)) $display("FAIL rand_conv n=%0d got %0b want %0b", n, b.converged, res < thr); else passed++;
         total++; if (b.overflow !== ovf) $display("FAIL rand_ovf n=%0d got %0b want %0b", n, b.overflow, ovf); else passed++;
         total++; if (ba !== 0) $display("FAIL rand_addr n=%0d got %0d bad addresses want 0", n, ba); else passed++;
         total++; if (bb !== 0) $display("FAIL rand_busy n=%0d got %0d bad cycles want 0", n, bb); else passed++;
      end
   endtask
   task automatic test_back_to_back;
      int lat, ba, bb;
      logic signed [63:0] r1, r2;
      logic ovf;
      for (int r = 0; r < 3; r++)
         for (int l = 0; l < 8; l++) mem[r][l*32 +: 32] = $urandom;
      model(3, 16, r1, ovf);
      run_sweep(3, AMAX, 2, lat, ba, bb);
      total++; if (lat !== 6) $display("FAIL busy_start_latency got %0d want 6", lat); else passed++;
      total++; if (b.result !== r1) $display("FAIL busy_start_result got %h want %h", b.result, r1); else passed++;
      total++; if (ba !== 0) $display("FAIL busy_start_addr got %0d bad addresses want 0", ba); else passed++;
      for (int r = 0; r < 2; r++)
         for (int l = 0; l < 8; l++) mem[r][l*32 +: 32] = $urandom;
      model(2, 16, r2, ovf);
      run_sweep(2, 64'sd0, 0, lat, ba, bb);
      total++; if (lat !== 5) $display("FAIL b2b_latency got %0d want 5", lat); else passed++;
      total++; if (b.result !== r2) $display("FAIL b2b_result got %h want %h", b.result, r2); else passed++;
      total++; if (ba !== 0) $display("FAIL b2b_addr got %0d bad addresses want 0", ba); else passed++;
      total++; if (b.converged !== (r2 < 0)) $display("FAIL b2b_conv got %0b want %0b", b.converged, r2 < 0); else passed++;
   endtask
   task automatic test_reset_mid;
      int lat, ba, bb;
      logic signed [63:0] res;
      logic ovf;
      for (int r = 0; r < 8; r++) mem[r] = {8{32'h0003_0000}};
      @(negedge clk);
      b.row_count = 20'd8;
      b.threshold = AMAX;
      b.start = 1'b1;
      @(posedge clk); #1;
      b.start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (b.busy !== 1'b0) $display("FAIL rmid_busy got %0b want 0", b.busy); else passed++;
      total++; if (b.result !== 64'd0) $display("FAIL rmid_result got %h want 0", b.result); else passed++;
      total++; if (b.input_read_address !== 20'd0) $display("FAIL rmid_addr got %0d want 0", b.input_read_address); else passed++;
      total++; if ({b.done, b.converged, b.overflow} !== 3'b000) $display("FAIL rmid_flags got %b want 000", {b.done, b.converged, b.overflow}); else passed++;
      @(negedge clk);
      reset = 1'b0;
      for (int l = 0; l < 8; l++) mem[0][l*32 +: 32] = $urandom;
      model(1, 16, res, ovf);
      run_sweep(1, AMAX, 0, lat, ba, bb);
      total++; if (lat !== 4) $display("FAIL rmid_latency got %0d want 4", lat); else passed++;
      total++; if (b.result !== res) $display("FAIL rmid_after_result got %h want %h", b.result, res); else passed++;
      total++; if (b.converged !== 1'b1) $display("FAIL rmid_after_conv got %0b want 1", b.converged); else passed++;
   endtask
   task automatic test_saturation;
      int lat;
      logic signed [63:0] res;
      logic ovf;
      mem[0] = {8{32'h7FFF_FFFF}};
      mem[1] = {8{32'h7FFF_FFFF}};
      model(2, 0, res, ovf);
      @(negedge clk);
      b0.row_count = 20'd2;
      b0.threshold = 64'sd0;
      b0.start = 1'b1;
      @(posedge clk); #1;
      b0.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (b0.done === 1'b1) begin
            lat = c;
            break;
         end
      end
      total++; if (lat !== 5) $display("FAIL sat_latency got %0d want 5", lat); else passed++;
      total++; if (b0.result !== AMAX) $display("FAIL sat_result got %h want %h", b0.result, AMAX); else passed++;
      total++; if (b0.result !== res) $display("FAIL sat_model got %h want %h", b0.result, res); else passed++;
      total++; if (b0.overflow !== 1'b1) $display("FAIL sat_ovf got %0b want 1", b0.overflow); else passed++;
      total++; if (b0.converged !== 1'b0) $display("FAIL sat_conv got %0b want 0", b0.converged); else passed++;
   endtask
   initial begin
      for (int r = 0; r < 64; r++) mem[r] = '0;
      test_reset;
      test_empty;
      test_all_ones;
      test_negative;
      test_random;
      test_back_to_back;
      test_reset_mid;
      test_saturation;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
